// File: rtl/seg7oct_rx.sv
// seg7oct_rx: qualifies an active-low 7-segment pattern and recovers the octal digit it shows,
// packing accepted digits into DIGITS-wide words. Define SEG7OCT_RX_ERRCNT_EN for err_cnt_o.
module seg7oct_rx #(
    parameter int unsigned STABLE_CYC = 4,
    parameter int unsigned DIGITS     = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic [6:0]          seg_i,
    output logic [2:0]          digit_o,
    output logic                valid_o,
    output logic                err_o,
    output logic [3*DIGITS-1:0] word_o,
    output logic                word_valid_o,
    output logic [3:0]          count_o,
    output logic [7:0]          err_cnt_o
);
    localparam int unsigned W        = 3 * DIGITS;
    localparam logic [7:0]  STABLE   = 8'(STABLE_CYC);
    localparam logic [3:0]  LAST_IDX = 4'(DIGITS - 1);

    typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

    state_e       state_q;
    logic [6:0]   seg_q;
    logic [7:0]   stab_q;
    logic [7:0]   stab_d;
    logic         changed;
    logic         qualify;
    logic         is_err;
    logic         pat_legal;
    logic         pat_blank;
    logic [2:0]   pat_digit;
    logic [W-1:0] digit_ext;

    always_comb begin
        pat_legal = 1'b1;
        pat_blank = 1'b0;
        pat_digit = 3'd0;
        case (seg_i)
            7'b1000000: pat_digit = 3'd0;
            7'b1111001: pat_digit = 3'd1;
            7'b0100100: pat_digit = 3'd2;
            7'b0110000: pat_digit = 3'd3;
            7'b0011001: pat_digit = 3'd4;
            7'b0010010: pat_digit = 3'd5;
            7'b0000010: pat_digit = 3'd6;
            7'b1111000: pat_digit = 3'd7;
            7'b1111111: begin
                pat_legal = 1'b0;
                pat_blank = 1'b1;
            end
            default: pat_legal = 1'b0;
        endcase
    end

    // Leaving IDLE treats the current pattern as new, same as a change on the bus.
    always_comb begin
        changed = (seg_i != seg_q);
        if (state_q == StIdle || changed) begin
            stab_d = 8'd1;
        end else if (stab_q >= STABLE) begin
            stab_d = STABLE;
        end else begin
            stab_d = stab_q + 8'd1;
        end
        qualify   = en_i && (state_q != StHold || changed) && (stab_d == STABLE);
        is_err    = qualify && !pat_legal && !pat_blank;
        digit_ext = '0;
        digit_ext[2:0] = pat_digit;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StWait;
            seg_q        <= 7'h7f;
            stab_q       <= '0;
            digit_o      <= '0;
            valid_o      <= 1'b0;
            err_o        <= 1'b0;
            word_o       <= '0;
            word_valid_o <= 1'b0;
            count_o      <= '0;
        end else begin
            seg_q        <= seg_i;
            valid_o      <= 1'b0;
            err_o        <= 1'b0;
            word_valid_o <= 1'b0;
            if (!en_i) begin
                state_q <= StIdle;
                stab_q  <= '0;
            end else begin
                stab_q <= stab_d;
                if (qualify) begin
                    state_q <= StHold;
                    if (pat_legal) begin
                        digit_o <= pat_digit;
                        valid_o <= 1'b1;
                        word_o  <= (word_o << 3) | digit_ext;
                        if (count_o == LAST_IDX) begin
                            count_o      <= '0;
                            word_valid_o <= 1'b1;
                        end else begin
                            count_o <= count_o + 4'd1;
                        end
                    end else if (is_err) begin
                        err_o   <= 1'b1;
                        count_o <= '0;
                    end
                end else if (state_q == StIdle || (state_q == StHold && changed)) begin
                    state_q <= StWait;
                end
            end
        end
    end

`ifdef SEG7OCT_RX_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt_q <= '0;
        end else if (is_err && err_cnt_q != 8'hff) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = 8'h00;
`endif

endmodule

// File: tb/tb_seg7oct_rx.sv
// Randomised scoreboard bench for seg7oct_rx: stimulus is a sequence of held patterns, a
// run-level model predicts each pulse and a monitor checks it when the DUT presents it.
module tb_seg7oct_rx;
    localparam int S = 4;
    localparam int D = 4;
    localparam logic [6:0] BLANK = 7'b1111111;

    typedef struct {
        bit is_err;
        int dig;
        int word;
        int cnt;
        bit wv;
        int ecnt;
        int at_edge;
    } exp_t;

    logic           clk;
    logic           rst_i;
    logic           en_i;
    logic [6:0]     seg_i;
    logic [2:0]     digit_o;
    logic           valid_o;
    logic           err_o;
    logic [3*D-1:0] word_o;
    logic           word_valid_o;
    logic [3:0]     count_o;
    logic [7:0]     err_cnt_o;

    seg7oct_rx #(
        .STABLE_CYC(S),
        .DIGITS    (D)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .seg_i       (seg_i),
        .digit_o     (digit_o),
        .valid_o     (valid_o),
        .err_o       (err_o),
        .word_o      (word_o),
        .word_valid_o(word_valid_o),
        .count_o     (count_o),
        .err_cnt_o   (err_cnt_o)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    int         edge_n = 0;
    exp_t       sb[$];
    exp_t       m;
    logic [6:0] pat_tbl [8];

    // Model state: a run is a maximal stretch of one pattern with en_i high.
    logic [6:0] prev_pat = BLANK;
    bit         fresh = 1'b1;
    int         mdl_word = 0;
    int         mdl_cnt = 0;
    int         mdl_ecnt = 0;
    int         mdl_dig = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) edge_n++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lookup(input logic [6:0] p);
        if (p == BLANK) return -2;
        for (int i = 0; i < 8; i++) if (pat_tbl[i] == p) return i;
        return -1;
    endfunction

    task automatic model_qual(input logic [6:0] p, input int at);
        exp_t e;
        int   k;
        k = lookup(p);
        if (k == -2) return;
        if (k == -1) begin
            mdl_cnt = 0;
`ifdef SEG7OCT_RX_ERRCNT_EN
            if (mdl_ecnt < 255) mdl_ecnt++;
`endif
            e.is_err = 1'b1;
            e.wv     = 1'b0;
        end else begin
            mdl_dig  = k;
            mdl_word = (mdl_word * 8 + k) % (1 << (3 * D));
            mdl_cnt++;
            e.wv     = (mdl_cnt == D);
            if (mdl_cnt == D) mdl_cnt = 0;
            e.is_err = 1'b0;
        end
        e.dig     = mdl_dig;
        e.word    = mdl_word;
        e.cnt     = mdl_cnt;
        e.ecnt    = mdl_ecnt;
        e.at_edge = at;
        sb.push_back(e);
    endtask

    // A new pattern held for at least S enabled edges is accepted exactly once.
    task automatic run(input logic [6:0] p, input int len);
        int start;
        start = edge_n + 1;
        if (len >= S && (fresh || p != prev_pat)) model_qual(p, start + S - 1);
        prev_pat = p;
        fresh    = 1'b0;
        for (int i = 0; i < len; i++) begin
            seg_i = p;
            en_i  = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic gap(input logic [6:0] p, input int len);
        fresh = 1'b1;
        for (int i = 0; i < len; i++) begin
            seg_i = p;
            en_i  = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_digit"}, 32'(digit_o), 0);
        chk({tag, "_valid"}, 32'(valid_o), 0);
        chk({tag, "_err"}, 32'(err_o), 0);
        chk({tag, "_word"}, 32'(word_o), 0);
        chk({tag, "_word_valid"}, 32'(word_valid_o), 0);
        chk({tag, "_count"}, 32'(count_o), 0);
        chk({tag, "_err_cnt"}, 32'(err_cnt_o), 0);
    endtask

    // Called at posedge+1; the reset lands mid-cycle and outputs are read before the next edge.
    task automatic do_reset();
        #2;
        rst_i = 1'b1;
        #1;
        check_zero("async_reset");
        chk("sb_empty_at_reset", sb.size(), 0);
        sb.delete();
        seg_i = BLANK;
        @(posedge clk);
        #1;
        rst_i    = 1'b0;
        fresh    = 1'b1;
        prev_pat = BLANK;
        mdl_word = 0;
        mdl_cnt  = 0;
        mdl_ecnt = 0;
        mdl_dig  = 0;
    endtask

    always @(negedge clk) begin
        if (!rst_i) begin
            if (valid_o && err_o) chk("valid_err_overlap", 1, 0);
            if (word_valid_o && !valid_o) chk("word_valid_without_valid", 1, 0);
            if (valid_o || err_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", {valid_o, err_o}, 0);
                end else begin
                    m = sb.pop_front();
                    chk("pulse_is_err", 32'(err_o), 32'(m.is_err));
                    chk("pulse_edge", edge_n, m.at_edge);
                    chk("digit", 32'(digit_o), m.dig);
                    chk("word", 32'(word_o), m.word);
                    chk("word_valid", 32'(word_valid_o), 32'(m.wv));
                    chk("count", 32'(count_o), m.cnt);
                    chk("err_cnt", 32'(err_cnt_o), m.ecnt);
                end
            end
        end
    end

    initial begin
        logic [6:0] p;
        int         r;
        pat_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};
        rst_i = 1'b1;
        en_i  = 1'b0;
        seg_i = BLANK;
        #2;
        check_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_i = 1'b0;

        // Single digit, then glitch rejection.
        run(7'b0100100, 4);
        run(7'b0110000, 3);
        run(7'b1111000, 1);
        run(7'b0110000, 4);
        run(BLANK, 2);

        // Full word 7,5,1,6 from a clean start.
        do_reset();
        run(7'b1111000, 4);
        run(BLANK, 4);
        run(7'b0010010, 4);
        run(BLANK, 4);
        run(7'b1111001, 4);
        run(BLANK, 4);
        run(7'b0000010, 4);
        run(BLANK, 2);
        chk("word_after_7516", 32'(word_o), 32'h0000_0f4e);
        chk("count_after_7516", 32'(count_o), 0);

        // Long hold accepted once, then an illegal pattern.
        run(7'b1111001, 20);
        run(7'b0000000, 4);
        run(BLANK, 2);
`ifdef SEG7OCT_RX_ERRCNT_EN
        chk("err_cnt_after_error", 32'(err_cnt_o), 1);
`else
        chk("err_cnt_after_error", 32'(err_cnt_o), 0);
`endif

        // Enable drop on the qualifying edge, then a fresh window.
        run(7'b0011001, 3);
        gap(7'b0011001, 2);
        run(7'b0011001, 4);

        // Reset with a partial word held.
        run(7'b0010010, 4);
        run(BLANK, 2);
        do_reset();

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 5) == 0) gap(7'($urandom), $urandom_range(1, 3));
            r = $urandom_range(0, 9);
            if (r < 8) p = pat_tbl[r];
            else if (r == 8) p = BLANK;
            else p = 7'($urandom);
            if (!fresh && p == prev_pat) p = (p == BLANK) ? pat_tbl[0] : BLANK;
            run(p, $urandom_range(1, S + 3));
        end

        gap(BLANK, 1);
        run(BLANK, S + 2);
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
